dual_port_fifo: RTL and testbench
=================================

DUAL_PORT_FIFO -- requirements
Module: dual_port_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 6, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, pointer width; depth = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter AF_LEVEL, default 6, occupancy at or above which oAlmostFull asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 1, occupancy at or below which oAlmostEmpty asserts.
REQ-005 The block SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port iReset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port iPush, input, 1, write request.
REQ-008 The block SHALL have port iDataIn, input, DATA_WIDTH, write data sampled with iPush.
REQ-009 The block SHALL have port iPop, input, 1, read request.
REQ-010 The block SHALL have port iClearErr, input, 1, synchronous clear of the sticky error flags.
REQ-011 The block SHALL have port oDataOut, output, DATA_WIDTH, registered read data.
REQ-012 The block SHALL have port oDataValid, output, 1, oDataOut holds a word popped on the previous cycle.
REQ-013 The block SHALL have ports oFull and oEmpty, output, 1 each, occupancy status.
REQ-014 The block SHALL have ports oAlmostFull and oAlmostEmpty, output, 1 each, threshold status.
REQ-015 The block SHALL have port oCount, output, ADDR_WIDTH+1, current occupancy, 0 to 2**ADDR_WIDTH.
REQ-016 The block SHALL have ports oOverflow and oUnderflow, output, 1 each, sticky error flags.

Function
REQ-017 Storage SHALL be a 2**ADDR_WIDTH x DATA_WIDTH array with one write port and one read port; the array itself SHALL NOT be reset.
REQ-018 The write pointer and read pointer SHALL each be ADDR_WIDTH+1 bits; the MSB SHALL be a wrap bit, and the lower bits SHALL address the array and wrap from 2**ADDR_WIDTH-1 to 0.
REQ-019 An accepted push (iPush=1 and (oFull=0 or an accepted pop in the same cycle)) SHALL write iDataIn at the write pointer and increment it.
REQ-020 An accepted pop (iPop=1 and oEmpty=0) SHALL register the word at the read pointer into oDataOut on that edge, increment the read pointer, and set oDataValid=1 for the following cycle; read latency SHALL be exactly 1 cycle.
REQ-021 oDataValid SHALL be 0 in any cycle following an edge without an accepted pop; oDataOut SHALL hold its last value when no pop is accepted.
REQ-022 oCount SHALL be write pointer minus read pointer, modulo 2**(ADDR_WIDTH+1), and SHALL be registered.
REQ-023 oEmpty SHALL be 1 iff oCount=0; oFull SHALL be 1 iff oCount=2**ADDR_WIDTH.
REQ-024 oAlmostFull SHALL be 1 iff oCount>=AF_LEVEL; oAlmostEmpty SHALL be 1 iff oCount<=AE_LEVEL.
REQ-025 Simultaneous push and pop when not empty SHALL both be accepted, oCount unchanged; when full, both SHALL be accepted and the pop SHALL return the oldest word, not the incoming one.
REQ-026 Simultaneous push and pop when empty: the push SHALL be accepted, the pop SHALL be rejected (no bypass), and oUnderflow SHALL be set.
REQ-027 A push while full without a pop SHALL be dropped, with no pointer or data change, and SHALL set oOverflow.
REQ-028 A pop while empty SHALL leave pointers unchanged and SHALL set oUnderflow.
REQ-029 oOverflow and oUnderflow SHALL remain 1 until iClearErr=1; if clear and a new error occur in the same cycle, the new error SHALL win.

Reset
REQ-030 While iReset_n=0, asynchronously: pointers=0, oCount=0, oEmpty=1, oFull=0, oAlmostEmpty=1 (AE_LEVEL>=0), oAlmostFull=0, oDataValid=0, oDataOut=0, oOverflow=0, oUnderflow=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored words; the first pop after release SHALL see oEmpty=1.

Verification
REQ-032 Reset, then 8 pushes of 0x01..0x08 -> oCount=8, oFull=1, oAlmostFull=1; then 8 pops -> oDataOut 0x01..0x08 in order, each with oDataValid one cycle after its pop; oEmpty=1 at the end.
REQ-033 Full FIFO, push 0x3F with no pop -> word dropped, oOverflow=1, oCount stays 8; iClearErr pulse -> oOverflow=0.
REQ-034 Empty FIFO, push 0x2A and pop in the same cycle -> oCount=1, oUnderflow=1, oDataValid=0; next-cycle pop -> oDataOut=0x2A, oDataValid=1.
REQ-035 Full FIFO, simultaneous push 0x15 and pop -> oDataOut is the oldest word, oCount stays 8; after 7 more pops, the final pop returns 0x15.
REQ-036 Wrap test, 20 interleaved push/pop pairs with random data -> data order preserved across pointer wrap; oCount tracked against a reference model every cycle.
REQ-037 Reset asserted with oCount=5 -> all outputs at REQ-030 values immediately, without waiting for a clock edge; a pop after release sets oUnderflow=1.

Source files
------------

// File: rtl/dual_port_fifo.sv
// Single-clock FIFO with a registered read port, registered occupancy count,
// threshold flags and sticky overflow/underflow error flags.
module dual_port_fifo #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 1
) (
   input  logic                  Clock,
   input  logic                  iReset_n,
   input  logic                  iPush,
   input  logic [DATA_WIDTH-1:0] iDataIn,
   input  logic                  iPop,
   input  logic                  iClearErr,
   output logic [DATA_WIDTH-1:0] oDataOut,
   output logic                  oDataValid,
   output logic                  oFull,
   output logic                  oEmpty,
   output logic                  oAlmostFull,
   output logic                  oAlmostEmpty,
   output logic [ADDR_WIDTH:0]   oCount,
   output logic                  oOverflow,
   output logic                  oUnderflow
);

   localparam int CW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  pop_acc, push_acc;
   logic                  is_full, is_empty;

   assign is_full  = (count_q == FULL_C);
   assign is_empty = (count_q == '0);

   // A full FIFO still takes a push when a pop frees a slot on the same edge.
   always_comb begin
      pop_acc  = iPop && !is_empty;
      push_acc = iPush && (!is_full || pop_acc);
      wr_ptr_d = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_acc  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = wr_ptr_d - rd_ptr_d;
      ovf_d    = (ovf_q && !iClearErr) || (iPush && !push_acc);
      unf_d    = (unf_q && !iClearErr) || (iPop && is_empty);
   end

   // Storage is not reset; read-before-write keeps the oldest word when full.
   always_ff @(posedge Clock) begin
      if (push_acc) begin
         mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= iDataIn;
      end
   end

   always_ff @(posedge Clock or negedge iReset_n) begin
      if (!iReset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= pop_acc;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         if (pop_acc) begin
            data_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
         end
      end
   end

   assign oDataOut     = data_q;
   assign oDataValid   = valid_q;
   assign oCount       = count_q;
   assign oFull        = is_full;
   assign oEmpty       = is_empty;
   assign oAlmostFull  = (count_q >= AF_C);
   assign oAlmostEmpty = (count_q <= AE_C);
   assign oOverflow    = ovf_q;
   assign oUnderflow   = unf_q;

endmodule

// File: tb/tb_dual_port_fifo.sv
// Randomised and directed checks of dual_port_fifo against a queue-based
// behavioural model of FIFO occupancy, data order and error flags.
module tb_dual_port_fifo;

   localparam int DEPTH = 8;

   logic       Clock = 1'b0;
   logic       iReset_n = 1'b0;
   logic       iPush = 1'b0;
   logic [5:0] iDataIn = '0;
   logic       iPop = 1'b0;
   logic       iClearErr = 1'b0;
   logic [5:0] oDataOut;
   logic       oDataValid, oFull, oEmpty, oAlmostFull, oAlmostEmpty;
   logic [3:0] oCount;
   logic       oOverflow, oUnderflow;

   int n_cmp = 0;
   int n_err = 0;

   logic [5:0] q[$];
   logic [5:0] m_dout = '0;
   logic       m_valid = 1'b0;
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   dual_port_fifo dut (
      .Clock(Clock), .iReset_n(iReset_n), .iPush(iPush), .iDataIn(iDataIn),
      .iPop(iPop), .iClearErr(iClearErr), .oDataOut(oDataOut),
      .oDataValid(oDataValid), .oFull(oFull), .oEmpty(oEmpty),
      .oAlmostFull(oAlmostFull), .oAlmostEmpty(oAlmostEmpty),
      .oCount(oCount), .oOverflow(oOverflow), .oUnderflow(oUnderflow)
   );

   always #5 Clock = ~Clock;

   // One clock cycle of stimulus; the model applies the FIFO rules to its queue.
   task automatic cycle(input logic push, input logic [5:0] d, input logic pop, input logic clr);
      bit pop_ok, push_ok;
      iPush = push; iDataIn = d; iPop = pop; iClearErr = clr;
      pop_ok  = pop && (q.size() != 0);
      push_ok = push && ((q.size() < DEPTH) || pop_ok);
      m_ovf   = (m_ovf && !clr) || (push && !push_ok);
      m_unf   = (m_unf && !clr) || (pop && (q.size() == 0));
      m_valid = pop_ok;
      if (pop_ok) m_dout = q.pop_front();
      if (push_ok) q.push_back(d);
      @(posedge Clock);
      #1;
      iPush = 1'b0; iPop = 1'b0; iClearErr = 1'b0;
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   task automatic test_reset();
      iReset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge Clock);
      #1;
      n_cmp++; if (oCount !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", oCount); end
      n_cmp++; if ({oEmpty, oFull, oAlmostEmpty, oAlmostFull} !== 4'b1010) begin
         n_err++; $display("FAIL reset_flags got E/F/AE/AF=%b exp=1010", {oEmpty, oFull, oAlmostEmpty, oAlmostFull}); end
      n_cmp++; if ({oDataValid, oDataOut, oOverflow, oUnderflow} !== 9'd0) begin
         n_err++; $display("FAIL reset_data got valid=%b dout=%h ovf=%b unf=%b exp all 0", oDataValid, oDataOut, oOverflow, oUnderflow); end
      @(negedge Clock);
      iReset_n = 1'b1;
      @(posedge Clock);
      #1;
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 6'(i + 1), 1'b0, 1'b0);
      n_cmp++; if (oCount !== 4'd8) begin n_err++; $display("FAIL fill_count got=%0d exp=8", oCount); end
      n_cmp++; if ({oFull, oAlmostFull, oEmpty} !== 3'b110) begin
         n_err++; $display("FAIL fill_flags got F/AF/E=%b exp=110", {oFull, oAlmostFull, oEmpty}); end
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 6'd0, 1'b1, 1'b0);
         n_cmp++; if (oDataValid !== 1'b1 || oDataOut !== 6'(i + 1)) begin
            n_err++; $display("FAIL drain_%0d got valid=%b dout=%h exp valid=1 dout=%h", i, oDataValid, oDataOut, 6'(i + 1)); end
      end
      cycle(1'b0, 6'd0, 1'b0, 1'b0);
      n_cmp++; if (oEmpty !== 1'b1 || oDataValid !== 1'b0 || oDataOut !== 6'h08) begin
         n_err++; $display("FAIL drain_end got E=%b valid=%b dout=%h exp E=1 valid=0 dout=08", oEmpty, oDataValid, oDataOut); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 6'(8'h10 + i), 1'b0, 1'b0);
      cycle(1'b1, 6'h3F, 1'b0, 1'b0);
      n_cmp++; if (oOverflow !== 1'b1 || oCount !== 4'd8) begin
         n_err++; $display("FAIL ovf_set got ovf=%b count=%0d exp ovf=1 count=8", oOverflow, oCount); end
      // Clear and a new overflow on the same edge: the new error wins.
      cycle(1'b1, 6'h3F, 1'b0, 1'b1);
      n_cmp++; if (oOverflow !== 1'b1) begin n_err++; $display("FAIL ovf_clr_vs_new got=%b exp=1", oOverflow); end
      cycle(1'b0, 6'd0, 1'b0, 1'b1);
      n_cmp++; if (oOverflow !== m_ovf || oOverflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b exp=0", oOverflow); end
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 6'd0, 1'b1, 1'b0);
         n_cmp++; if (oDataOut !== 6'(8'h10 + i)) begin
            n_err++; $display("FAIL ovf_drain_%0d got=%h exp=%h", i, oDataOut, 6'(8'h10 + i)); end
      end
   endtask

   task automatic test_empty_push_pop();
      cycle(1'b1, 6'h2A, 1'b1, 1'b0);
      n_cmp++; if (oCount !== 4'd1 || oUnderflow !== 1'b1 || oDataValid !== 1'b0) begin
         n_err++; $display("FAIL empty_pp got count=%0d unf=%b valid=%b exp 1/1/0", oCount, oUnderflow, oDataValid); end
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
      n_cmp++; if (oDataOut !== 6'h2A || oDataValid !== 1'b1) begin
         n_err++; $display("FAIL empty_pp_pop got dout=%h valid=%b exp 2a/1", oDataOut, oDataValid); end
      cycle(1'b0, 6'd0, 1'b0, 1'b1);
      n_cmp++; if (oUnderflow !== 1'b0) begin n_err++; $display("FAIL unf_clear got=%b exp=0", oUnderflow); end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 6'(8'h20 + i), 1'b0, 1'b0);
      cycle(1'b1, 6'h15, 1'b1, 1'b0);
      n_cmp++; if (oDataOut !== 6'h20 || oCount !== 4'd8 || oOverflow !== 1'b0) begin
         n_err++; $display("FAIL full_pp got dout=%h count=%0d ovf=%b exp 20/8/0", oDataOut, oCount, oOverflow); end
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 6'd0, 1'b1, 1'b0);
      n_cmp++; if (oDataOut !== 6'h15 || oEmpty !== 1'b1) begin
         n_err++; $display("FAIL full_pp_last got dout=%h empty=%b exp 15/1", oDataOut, oEmpty); end
   endtask

   task automatic test_wrap();
      int sz;
      for (int i = 0; i < 3; i++) cycle(1'b1, 6'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         // Mostly push/pop pairs, with occasional one-sided cycles to vary occupancy.
         cycle(($urandom_range(0, 3) != 0), 6'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
         sz = q.size();
         n_cmp++; if (oCount !== 4'(sz)) begin n_err++; $display("FAIL wrap_count_%0d got=%0d exp=%0d", i, oCount, sz); end
         n_cmp++; if ({oFull, oEmpty, oAlmostFull, oAlmostEmpty} !== {sz == DEPTH, sz == 0, sz >= 6, sz <= 1}) begin
            n_err++; $display("FAIL wrap_flags_%0d got F/E/AF/AE=%b for occupancy %0d", i, {oFull, oEmpty, oAlmostFull, oAlmostEmpty}, sz); end
         n_cmp++; if (oDataValid !== m_valid || (m_valid && oDataOut !== m_dout)) begin
            n_err++; $display("FAIL wrap_data_%0d got valid=%b dout=%h exp valid=%b dout=%h", i, oDataValid, oDataOut, m_valid, m_dout); end
         n_cmp++; if (oOverflow !== m_ovf || oUnderflow !== m_unf) begin
            n_err++; $display("FAIL wrap_err_%0d got ovf=%b unf=%b exp ovf=%b unf=%b", i, oOverflow, oUnderflow, m_ovf, m_unf); end
      end
   endtask

   task automatic test_async_reset();
      while (q.size() > 0) cycle(1'b0, 6'd0, 1'b1, 1'b0);
      cycle(1'b0, 6'd0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b1, 6'(8'h30 + i), 1'b0, 1'b0);
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
      cycle(1'b1, 6'h3A, 1'b0, 1'b0);
      n_cmp++; if (oCount !== 4'd5 || oDataValid !== 1'b0) begin
         n_err++; $display("FAIL pre_reset got count=%0d valid=%b exp 5/0", oCount, oDataValid); end
      #2;
      iReset_n = 1'b0;
      model_reset();
      #1;
      n_cmp++; if (oCount !== 4'd0 || {oEmpty, oFull, oAlmostEmpty, oAlmostFull} !== 4'b1010) begin
         n_err++; $display("FAIL async_rst_status got count=%0d E/F/AE/AF=%b exp 0/1010", oCount, {oEmpty, oFull, oAlmostEmpty, oAlmostFull}); end
      n_cmp++; if ({oDataValid, oDataOut, oOverflow, oUnderflow} !== 9'd0) begin
         n_err++; $display("FAIL async_rst_data got valid=%b dout=%h ovf=%b unf=%b exp all 0", oDataValid, oDataOut, oOverflow, oUnderflow); end
      @(negedge Clock);
      iReset_n = 1'b1;
      @(posedge Clock);
      #1;
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
      n_cmp++; if (oUnderflow !== 1'b1 || oDataValid !== 1'b0 || oCount !== 4'd0) begin
         n_err++; $display("FAIL post_reset_pop got unf=%b valid=%b count=%0d exp 1/0/0", oUnderflow, oDataValid, oCount); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_empty_push_pop();
      test_full_push_pop();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
